// File: rtl/dmadd_engine.sv
// ============================================================================
// Module      : dmadd_engine
// Description : BINS accumulating bins with a start/busy/done scan that
//               reports MIN index, MAX index, weighted sum or non-zero count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmadd_engine #(
  parameter int BINS   = 16,
  parameter int IDX_W  = $clog2(BINS),
  parameter int DATA_W = 4,
  parameter int MEM_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [OUT_W-1:0]  result
);

  localparam logic [1:0]       c_MODE_MIN   = 2'b00;
  localparam logic [1:0]       c_MODE_MAX   = 2'b01;
  localparam logic [1:0]       c_MODE_WSUM  = 2'b10;
  localparam logic [1:0]       c_MODE_COUNT = 2'b11;
  localparam logic [IDX_W-1:0] c_PTR_LAST   = IDX_W'(BINS - 1);
  localparam logic [IDX_W-1:0] c_PTR_ONE    = IDX_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [MEM_W-1:0]   r_bins [BINS];
  logic [1:0]         r_mode, w_mode_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [OUT_W-1:0]   r_suffix, w_suffix_nxt;
  logic [OUT_W-1:0]   r_total, w_total_nxt;
  logic               r_done, w_done_nxt;
  logic               r_found, w_found_nxt;
  logic [OUT_W-1:0]   r_result, w_result_nxt;
  logic               w_wr;
  logic [MEM_W-1:0]   w_bin;
  logic               w_bin_nz;
  logic [OUT_W-1:0]   w_suffix_sum;
  logic [OUT_W-1:0]   w_wsum_total;

  always_ff @(posedge clk) begin
    if (rst || clear) r_state <= S_IDLE;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_bin        = r_bins[r_ptr];
    w_bin_nz     = |w_bin;
    w_suffix_sum = r_suffix + OUT_W'(w_bin);
    // Bin 0 contributes to the suffix only; its weight is zero.
    w_wsum_total = (r_ptr != '0) ? (r_total + w_suffix_sum) : r_total;

    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_ptr_nxt    = r_ptr;
    w_suffix_nxt = r_suffix;
    w_total_nxt  = r_total;
    w_done_nxt   = 1'b0;
    w_found_nxt  = r_found;
    w_result_nxt = r_result;
    w_wr         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_SCAN;
          w_mode_nxt   = mode;
          w_ptr_nxt    = (mode == c_MODE_MIN) ? '0 : c_PTR_LAST;
          w_suffix_nxt = '0;
          w_total_nxt  = '0;
        end else begin
          w_wr = wr_en;
        end
      end
      S_SCAN: begin
        case (r_mode)
          c_MODE_MIN: begin
            if (w_bin_nz || r_ptr == c_PTR_LAST) begin
              w_state_nxt  = S_IDLE;
              w_done_nxt   = 1'b1;
              w_found_nxt  = w_bin_nz;
              w_result_nxt = w_bin_nz ? OUT_W'(r_ptr) : '0;
            end else begin
              w_ptr_nxt = r_ptr + c_PTR_ONE;
            end
          end
          c_MODE_MAX: begin
            if (w_bin_nz || r_ptr == '0) begin
              w_state_nxt  = S_IDLE;
              w_done_nxt   = 1'b1;
              w_found_nxt  = w_bin_nz;
              w_result_nxt = w_bin_nz ? OUT_W'(r_ptr) : '0;
            end else begin
              w_ptr_nxt = r_ptr - c_PTR_ONE;
            end
          end
          c_MODE_WSUM: begin
            w_suffix_nxt = w_suffix_sum;
            w_total_nxt  = w_wsum_total;
            if (r_ptr == '0) begin
              w_state_nxt  = S_IDLE;
              w_done_nxt   = 1'b1;
              w_found_nxt  = 1'b1;
              w_result_nxt = w_wsum_total;
            end else begin
              w_ptr_nxt = r_ptr - c_PTR_ONE;
            end
          end
          c_MODE_COUNT: begin
            w_total_nxt = r_total + OUT_W'(w_bin_nz);
            if (r_ptr == '0) begin
              w_state_nxt  = S_IDLE;
              w_done_nxt   = 1'b1;
              w_found_nxt  = 1'b1;
              w_result_nxt = r_total + OUT_W'(w_bin_nz);
            end else begin
              w_ptr_nxt = r_ptr - c_PTR_ONE;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= 2'b00;
      r_ptr    <= '0;
      r_suffix <= '0;
      r_total  <= '0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_result <= '0;
    end else if (clear) begin
      r_done <= 1'b0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_ptr    <= w_ptr_nxt;
      r_suffix <= w_suffix_nxt;
      r_total  <= w_total_nxt;
      r_done   <= w_done_nxt;
      r_found  <= w_found_nxt;
      r_result <= w_result_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < BINS; i++) r_bins[i] <= '0;
    end else if (w_wr) begin
      r_bins[wr_idx] <= r_bins[wr_idx] + MEM_W'(wr_data);
    end
  end

  assign busy   = (r_state == S_SCAN);
  assign done   = r_done;
  assign found  = r_found;
  assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_dmadd_engine.sv
// ============================================================================
// Module      : tb_dmadd_engine
// Description : Directed self-checking bench for dmadd_engine (default sizes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmadd_engine;

  localparam int BINS   = 16;
  localparam int IDX_W  = 4;
  localparam int DATA_W = 4;
  localparam int MEM_W  = 8;
  localparam int OUT_W  = 16;

  localparam logic [1:0] c_MIN   = 2'b00;
  localparam logic [1:0] c_MAX   = 2'b01;
  localparam logic [1:0] c_WSUM  = 2'b10;
  localparam logic [1:0] c_COUNT = 2'b11;

  logic              clk = 1'b0;
  logic              rst, clear, wr_en, start;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        mode;
  logic              busy, done, found;
  logic [OUT_W-1:0]  result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmadd_engine #(
    .BINS(BINS), .IDX_W(IDX_W), .DATA_W(DATA_W), .MEM_W(MEM_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .mode(mode), .start(start), .busy(busy), .done(done),
    .found(found), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int data);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(idx);
    wr_data = DATA_W'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Starts a scan now and counts edges from the start edge until done.
  task automatic scan(input logic [1:0] m, input int exp_v, input int exp_res,
                      input logic exp_found, input string tag);
    int n;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
    check({tag, "_latency"}, 32'(n), 32'(exp_v));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_found"}, 32'(found), 32'(exp_found));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  n;
    logic saw_done;
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; start = 1'b0;
    wr_idx = '0; wr_data = '0; mode = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_result", 32'(result), 32'd0);

    // Empty bins
    scan(c_MIN, 16, 0, 1'b0, "empty_min");
    scan(c_COUNT, 16, 0, 1'b1, "empty_count");

    // Basic contents: bin3=5, bin9=3
    wr(3, 5); wr(9, 2); wr(9, 1);
    scan(c_MIN, 4, 3, 1'b1, "basic_min");
    scan(c_MAX, 7, 9, 1'b1, "basic_max");
    scan(c_COUNT, 16, 2, 1'b1, "basic_count");
    scan(c_WSUM, 16, 42, 1'b1, "wsum1");
    scan(c_WSUM, 16, 42, 1'b1, "wsum2");

    // Bin wraparound
    pulse_clear();
    repeat (18) wr(1, 15);
    scan(c_WSUM, 16, 14, 1'b1, "wrap_bin1");
    repeat (5) wr(15, 15);
    wr(15, 5);
    scan(c_WSUM, 16, 1214, 1'b1, "wrap_bin15");

    // Abort a WSUM with clear
    pulse_clear();
    wr(3, 5); wr(9, 2); wr(9, 1);
    mode = c_WSUM; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    saw_done = 1'b0;
    repeat (20) begin
      if (done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_result_hold", 32'(result), 32'd1214);
    scan(c_MIN, 16, 0, 1'b0, "abort_min");

    // wr_en and start during SCAN are ignored
    wr(5, 3);
    mode = c_COUNT; start = 1'b1;
    tick();
    wr_en = 1'b1; wr_idx = 4'd7; wr_data = 4'd4; mode = c_MIN;
    repeat (3) tick();
    wr_en = 1'b0; start = 1'b0;
    n = 3;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
    check("busy_ign_latency", 32'(n), 32'd16);
    check("busy_ign_result", 32'(result), 32'd1);
    scan(c_MAX, 11, 5, 1'b1, "busy_ign_max");

    // start + wr_en in the same IDLE cycle drops the write
    pulse_clear();
    wr_en = 1'b1; wr_idx = 4'd2; wr_data = 4'd7;
    scan(c_MIN, 16, 0, 1'b0, "start_wr_min");

    // start in the done cycle launches a new scan
    wr(4, 1);
    scan(c_MIN, 5, 4, 1'b1, "dc_min");
    check("dc_done_high", 32'(done), 32'd1);
    scan(c_MAX, 12, 4, 1'b1, "dc_max");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
